uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- 8N1 UART receiver for the SOC's currently unused RXD pin; the receive-side counterpart of the emitter UART.
- Oversamples RXD with a cycle counter derived from CLK_FREQ_HZ/BAUD_RATE and assembles bytes LSB first.
- Pushes good bytes into a small FIFO and flags framing and overrun errors.
- The SOC IO page decodes reads onto this block: data register reads pulse rd_stb (pop); the status register exposes rd_valid, count and the error flags.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 1000000, line rate in bit/s. DIV = CLK_FREQ_HZ/BAUD_RATE (integer division) is the number of clocks per bit; DIV >= 4 is required. HALF = DIV/2.
- FIFO_DEPTH, 4, receive FIFO entries. Power of two, >= 2.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; synchronous, active-low; clock clk
- rxd  in  1  asynchronous serial input; idle high
- rd_stb  in  1  pop FIFO head this cycle; ignored when empty
- rd_data  out  8  FIFO head byte; valid when rd_valid=1
- rd_valid  out  1  FIFO non-empty
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte dropped because FIFO full
- err_clr  in  1  clears frame_err and overrun

Behaviour:
- Synchroniser: 2-FF chain rxd -> rxd_s. Both FFs reset to 1. All FSM decisions use rxd_s only.
- Reset (resetn=0 at a clk edge):
  - FSM goes to WAIT_HIGH; bit counter and index cleared.
  - FIFO emptied: rd_valid=0, rx_count=0, rd_data=0.
  - frame_err=0, overrun=0.
- FSM states: WAIT_HIGH, IDLE, START, DATA, STOP. Counter cnt counts down; a "tick" is a cycle with cnt==0.
  - WAIT_HIGH: go to IDLE on the first cycle with rxd_s==1. Prevents false starts after reset or during a break.
  - IDLE: on rxd_s==0, load cnt=HALF-1 and go to START.
  - START, on tick: if rxd_s==1 it was a glitch; go to IDLE with no flags. Otherwise load cnt=DIV-1, idx=0, go to DATA.
  - DATA, on tick: shift = {rxd_s, shift[7:1]}, then idx++. After the 8th bit load cnt=DIV-1 and go to STOP; otherwise reload cnt=DIV-1.
  - STOP, on tick:
    - rxd_s==1: push shift into the FIFO (or set overrun if the push is refused), go to IDLE.
    - rxd_s==0: set frame_err, discard the byte, go to WAIT_HIGH.
- Sample timing: with t0 = the cycle IDLE sees rxd_s==0, the start bit is sampled at t0+HALF, data bit n at t0+HALF+(n+1)*DIV, and the stop bit at t0+HALF+9*DIV. rd_valid rises on the cycle after the stop sample.
- Back-to-back frames: a start edge is accepted from the cycle after the stop sample. No idle gap is required.
- FIFO:
  - Circular buffer with wr/rd pointers of width $clog2(FIFO_DEPTH) that wrap naturally.
  - rd_data is the head entry, presented combinationally from the register array.
  - Pop: rd_stb && rd_valid. rd_data updates to the next entry on the following cycle.
  - Push when not full: accepted.
  - Push when full with a simultaneous pop: accepted, no overrun; count unchanged.
  - Push when full without a pop: byte dropped, overrun set, FIFO contents unchanged.
  - Pop when empty: no effect; count never underflows.
- Error flags:
  - Sticky until err_clr=1 at a clk edge.
  - A set event and err_clr in the same cycle: the flag ends set (set wins).
  - Errors never block reception.
- Reset mid-frame aborts the frame silently; the partial byte is lost and no flags are set.

Test Plan:
- Params 1600000/100000 (DIV=16, HALF=8), depth 4. Send 0x55 8N1 -> rd_valid rises exactly 8+9*16+1=153 cycles after rxd_s first reads 0; rd_data=0x55, rx_count=1. Pulse rd_stb -> next cycle rd_valid=0, rx_count=0.
- rxd low for 4 cycles then high -> no byte, frame_err=0, FSM back in IDLE. A subsequent 0xC3 is received correctly.
- Send 0xA3 with stop bit 0, hold line low 40 more cycles:
  - Expect frame_err=1, FIFO empty, no extra bytes during the low period.
  - Raise line, send 0x3C -> rd_data=0x3C, frame_err stays 1.
  - err_clr -> frame_err=0.
- Send 0x01..0x05 back-to-back with no pops -> rx_count=4, overrun=1. Pops return 01,02,03,04 then rd_valid=0.
- Repeat the overrun run with rd_stb asserted in the stop-sample cycle of byte 5 -> overrun=0, FIFO holds 02..05.
- Assert resetn=0 for 1 cycle during data bit 3 of 0x96 while rxd is low:
  - Outputs cleared.
  - No byte and no error from the remainder of the frame.
  - The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 UART receiver with a small receive FIFO and sticky error
//             flags. RXD is synchronised, sampled mid-bit using a down
//             counter of CLK_FREQ_HZ/BAUD_RATE clocks per bit, and assembled
//             LSB first.
//  Ports    : clk        - system clock
//             resetn     - synchronous, active-low reset
//             rxd        - asynchronous serial input, idle high
//             rd_stb     - pop the FIFO head (ignored when empty)
//             rd_data    - FIFO head byte, valid while rd_valid=1
//             rd_valid   - FIFO non-empty
//             rx_count   - FIFO occupancy
//             frame_err  - sticky: stop bit sampled low
//             overrun    - sticky: byte dropped because the FIFO was full
//             err_clr    - clears frame_err and overrun
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 1000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          rxd,
   input  logic                          rd_stb,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF  = DIV / 2;
   localparam int CW    = $clog2(DIV);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int NW    = AW + 1;

   localparam logic [CW-1:0] c_DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] c_HALF_M1 = CW'(HALF - 1);
   localparam logic [NW-1:0] c_FULL    = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      WAIT_HIGH = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } state_t;

   // -------------------------------------------------------------------------
   // Input synchroniser; both stages reset to the idle (high) level
   // -------------------------------------------------------------------------
   logic rxd_meta_q;
   logic rxd_s_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   // -------------------------------------------------------------------------
   // Receive FSM
   // -------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [2:0]      idx_q,   idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            w_tick;
   logic            w_push_req;
   logic            w_ferr_set;

   assign w_tick = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= WAIT_HIGH;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      w_push_req = 1'b0;
      w_ferr_set = 1'b0;

      case (state_q)
         // Waiting for the line to return high avoids treating a held-low
         // line (break, or reset mid-frame) as a new start bit.
         WAIT_HIGH: begin
            if (rxd_s_q) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (!rxd_s_q) begin
               cnt_d   = c_HALF_M1;
               state_d = START;
            end
         end

         START: begin
            if (w_tick) begin
               if (rxd_s_q) begin
                  // Line back high at mid start bit: noise, not a frame.
                  state_d = IDLE;
               end else begin
                  cnt_d   = c_DIV_M1;
                  idx_d   = '0;
                  state_d = DATA;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         DATA: begin
            if (w_tick) begin
               shift_d = {rxd_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               cnt_d   = c_DIV_M1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         STOP: begin
            if (w_tick) begin
               if (rxd_s_q) begin
                  w_push_req = 1'b1;
                  state_d    = IDLE;
               end else begin
                  w_ferr_set = 1'b1;
                  state_d    = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = WAIT_HIGH;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Receive FIFO
   // -------------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NW-1:0] count_q,  count_d;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_ovr_set;

   assign w_full    = (count_q == c_FULL);
   assign w_pop     = rd_stb && (count_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push    = w_push_req && (!w_full || w_pop);
   assign w_ovr_set = w_push_req && w_full && !w_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + NW'(w_push) - NW'(w_pop);
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign rd_valid = (count_q != '0);
   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign rx_count = count_q;

   // -------------------------------------------------------------------------
   // Sticky error flags; a set event in the clearing cycle wins
   // -------------------------------------------------------------------------
   logic frame_err_q, frame_err_d;
   logic overrun_q,   overrun_d;

   assign frame_err_d = w_ferr_set | (frame_err_q & ~err_clr);
   assign overrun_d   = w_ovr_set  | (overrun_q   & ~err_clr);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver (DIV=16, depth 4).
//             Expected bytes are queued as frames are sent and compared
//             when popped.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

   localparam int DEPTH = 4;

   logic       clk    = 1'b0;
   logic       resetn = 1'b0;
   logic       rxd    = 1'b1;
   logic       rd_stb = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [2:0] rx_count;
   logic       frame_err;
   logic       overrun;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] sb[$];
   logic       exp_ferr = 1'b0;
   logic       exp_ovr  = 1'b0;
   int         rise_iter;

   uart_receiver #(
      .CLK_FREQ_HZ(1600000),
      .BAUD_RATE  (100000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .rxd      (rxd),
      .rd_stb   (rd_stb),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rx_count (rx_count),
      .frame_err(frame_err),
      .overrun  (overrun),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Line level at cycle i of a 160-cycle frame (16 clocks per bit).
   function automatic logic line_level(input logic [7:0] b, input logic stop, input int i);
      if (i < 16)  return 1'b0;
      if (i < 144) return b[(i - 16) / 16];
      return stop;
   endfunction

   // Drives one frame. pop_cyc/clr_cyc select a cycle in which rd_stb /
   // err_clr are asserted (-1 for none). Cycle 154 is the stop-sample cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int pop_cyc, input int clr_cyc);
      rise_iter = -1;
      for (int i = 0; i < 160; i++) begin
         if (rise_iter < 0 && rd_valid) rise_iter = i;
         if (i == 155) begin
            if (stop) begin
               if (sb.size() < DEPTH) sb.push_back(b);
               else                   exp_ovr = 1'b1;
            end else begin
               exp_ferr = 1'b1;
            end
         end
         rxd     = line_level(b, stop, i);
         rd_stb  = (i == pop_cyc);
         err_clr = (i == clr_cyc);
         if (i == pop_cyc) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL inframe_pop: popped with no byte expected, rd_valid=%0b", rd_valid);
            end else begin
               if (rd_valid !== 1'b1 || rd_data !== sb[0]) begin
                  bad++;
                  $display("FAIL inframe_pop: got valid=%0b data=%02h, want valid=1 data=%02h",
                           rd_valid, rd_data, sb[0]);
               end
               void'(sb.pop_front());
            end
         end
         if (i == clr_cyc) begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
         end
         step();
      end
      rd_stb  = 1'b0;
      err_clr = 1'b0;
      total++;
      if (rx_count !== 3'(sb.size())) begin
         bad++;
         $display("FAIL frame_count(%02h): got %0d, want %0d", b, rx_count, sb.size());
      end
      total++;
      if (frame_err !== exp_ferr) begin
         bad++;
         $display("FAIL frame_err(%02h): got %0b, want %0b", b, frame_err, exp_ferr);
      end
      total++;
      if (overrun !== exp_ovr) begin
         bad++;
         $display("FAIL overrun(%02h): got %0b, want %0b", b, overrun, exp_ovr);
      end
   endtask

   task automatic pop_check();
      logic [7:0] exp;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL pop: scoreboard empty, rd_valid=%0b rd_data=%02h", rd_valid, rd_data);
      end else begin
         exp = sb.pop_front();
         if (rd_valid !== 1'b1 || rd_data !== exp) begin
            bad++;
            $display("FAIL pop: got valid=%0b data=%02h, want valid=1 data=%02h",
                     rd_valid, rd_data, exp);
         end
      end
      rd_stb = 1'b1;
      step();
      rd_stb = 1'b0;
      total++;
      if (rx_count !== 3'(sb.size()) || rd_valid !== (sb.size() != 0)) begin
         bad++;
         $display("FAIL pop_after: got count=%0d valid=%0b, want count=%0d",
                  rx_count, rd_valid, sb.size());
      end
   endtask

   task automatic check_cleared(input string tag);
      total++;
      if (rd_valid !== 1'b0 || rx_count !== 3'd0 || rd_data !== 8'h00 ||
          frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL %s: got valid=%0b count=%0d data=%02h ferr=%0b ovr=%0b, want all 0",
                  tag, rd_valid, rx_count, rd_data, frame_err, overrun);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      rxd    = 1'b1;
      repeat (3) step();
      resetn = 1'b1;
      step();
      check_cleared("reset");
   endtask

   task automatic test_basic();
      send_frame(8'h55, 1'b1, -1, -1);
      total++;
      if (rise_iter != 155) begin
         bad++;
         $display("FAIL latency: rd_valid rose at %0d, want 155 (153 after rxd_s low)", rise_iter);
      end
      pop_check();
   endtask

   task automatic test_glitch();
      rxd = 1'b0;
      repeat (4) step();
      rxd = 1'b1;
      repeat (40) step();
      total++;
      if (rd_valid !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL glitch: got valid=%0b ferr=%0b, want 0 0", rd_valid, frame_err);
      end
      send_frame(8'hC3, 1'b1, -1, -1);
      pop_check();
   endtask

   task automatic test_framing();
      logic seen;
      seen = 1'b0;
      send_frame(8'hA3, 1'b0, -1, -1);
      for (int i = 0; i < 40; i++) begin
         if (rd_valid) seen = 1'b1;
         step();
      end
      total++;
      if (seen || rx_count !== 3'd0 || frame_err !== 1'b1) begin
         bad++;
         $display("FAIL break: got byte_seen=%0b count=%0d ferr=%0b, want 0 0 1",
                  seen, rx_count, frame_err);
      end
      rxd = 1'b1;
      repeat (20) step();
      send_frame(8'h3C, 1'b1, -1, -1);
      pop_check();
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL ferr_sticky: got %0b, want 1", frame_err);
      end
      err_clr = 1'b1;
      step();
      err_clr  = 1'b0;
      exp_ferr = 1'b0;
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_clear: got %0b, want 0", frame_err);
      end
   endtask

   task automatic test_overrun();
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, -1, -1);
      // Clear in the same cycle as a new overrun: the flag must stay set.
      send_frame(8'h06, 1'b1, -1, 154);
      for (int k = 0; k < 4; k++) pop_check();
      rd_stb = 1'b1;
      step();
      rd_stb = 1'b0;
      total++;
      if (rx_count !== 3'd0 || rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_pop: got count=%0d valid=%0b, want 0 0", rx_count, rd_valid);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_ovr = 1'b0;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_clear: got %0b, want 0", overrun);
      end
   endtask

   task automatic test_back_to_back_pop();
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, -1, -1);
      send_frame(8'h05, 1'b1, 154, -1);
      for (int k = 0; k < 4; k++) pop_check();
   endtask

   task automatic test_reset_midframe();
      logic seen;
      send_frame(8'h77, 1'b1, -1, -1);
      send_frame(8'h12, 1'b0, -1, -1);
      rxd = 1'b1;
      repeat (20) step();
      // Abort 0x96 inside data bit 3, which is low.
      for (int i = 0; i < 71; i++) begin
         rxd = line_level(8'h96, 1'b1, i);
         step();
      end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      rxd    = 1'b1;
      sb.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      check_cleared("midframe_reset");
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (rd_valid || frame_err) seen = 1'b1;
         step();
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL post_reset: got byte or error after reset, want none");
      end
      send_frame(8'h5A, 1'b1, -1, -1);
      pop_check();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back_pop();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
